amo_sequencer: RTL
==================

// Module: amo_sequencer
// PURPOSE
//   Sits between the core's data-memory port (slave side of the core data bus) and a plain
//   single-outstanding memory bus. Passes ordinary loads/stores through. Expands AMO requests
//   into a read-modify-write sequence. Implements LR/SC with a one-entry reservation.
//   Ordering is strict: one request in flight, so aq/rl are satisfied trivially and otherwise ignored.
// PARAMETERS
//   XLEN        64  address width
//   DATA_WIDTH  64  bus data width; mask width = DATA_WIDTH/8
// PORTS
//   clk       in   1       clock
//   rst       in   1       asynchronous, active-high reset
//   s_valid   in   1       core request valid
//   s_ready   out  1       request accepted when s_valid && s_ready
//   s_addr    in   XLEN    byte address
//   s_wen     in   1       1 = store (ignored when s_is_amo)
//   s_wdata   in   DW      store data / AMO rs2, already placed in its byte lanes
//   s_wmask   in   DW/8    byte-lane mask
//   s_is_amo  in   1       request is an A-extension op
//   s_aq,s_rl in   1       ordering bits (ignored)
//   s_amoop   in   5       AMOOp: ADD=00000 SWAP=00001 LR=00010 SC=00011 XOR=00100
//                          OR=01000 AND=01100 MIN=10000 MAX=10100 MINU=11000 MAXU=11100
//   s_funct3  in   3       010 = .W, 011 = .D
//   s_rvalid  out  1       one-cycle response pulse, one per accepted request
//   s_rdata   out  DW      raw memory data (loads/AMO/LR), or SC result (0 = success, 1 = fail)
//   m_valid   out  1       memory bus request
//   m_ready   in   1       memory bus accept
//   m_addr    out  XLEN    byte address
//   m_wen     out  1       write enable
//   m_wdata   out  DW      write data
//   m_wmask   out  DW/8    write mask
//   m_rvalid  in   1       one pulse per accepted memory request (reads and writes)
//   m_rdata   in   DW      read data, valid with m_rvalid
// BEHAVIOUR
//   Reset: state=IDLE. rsv_valid=0. All outputs 0 except s_ready=1. Reset mid-operation
//     abandons the sequence; m_valid drops immediately. No s_rvalid is produced.
//   Request capture: s_ready=1 only in IDLE. On accept, all s_* request fields are registered.
//   FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
//   - Plain load: IDLE -> RD_REQ -> RD_WAIT -> RESP. s_rdata = m_rdata.
//   - Plain store: IDLE -> WR_REQ -> WR_WAIT -> RESP.
//   - LR: same path as a load. On m_rvalid, set rsv_valid=1 and rsv_addr=addr.
//   - SC, success (rsv_valid && rsv_addr==addr): WR_REQ -> WR_WAIT -> RESP, s_rdata=0.
//   - SC, failure: IDLE -> RESP directly. No bus access. s_rdata=1.
//     rsv_valid is cleared in the capture cycle in both SC cases.
//   - Other AMO: RD_REQ -> RD_WAIT; the old value is latched at m_rvalid. Then WR_REQ with
//     m_wdata=f(old,rs2) and m_wmask=s_wmask -> WR_WAIT -> RESP. s_rdata = latched old data.
//   Memory bus handshake: in *_REQ states m_valid=1. Address/data stay stable until m_ready.
//     The request is accepted in the m_ready cycle, which moves the FSM to *_WAIT.
//     *_WAIT holds until m_rvalid. m_rvalid is ignored in any other state.
//   Response: RESP lasts exactly 1 cycle with s_rvalid=1, then returns to IDLE.
//     Back-to-back requests are therefore at most one per (bus latency + 3) cycles.
//   AMO arithmetic:
//   - .D: 64-bit operation.
//   - .W: operate on the 32-bit lane selected by addr[2]. The other lane is written back
//     unchanged but masked off by s_wmask.
//   - MIN/MAX use a signed compare; MINU/MAXU use an unsigned compare.
//     On equal operands, either value is correct (results are identical).
//   - ADD wraps modulo 2^32 (.W) or 2^64 (.D).
//   Reservation invalidation: any plain store or AMO write whose addr[XLEN-1:3] equals
//     rsv_addr[XLEN-1:3] clears rsv_valid on its m_ready handshake. A new LR overwrites rsv_addr.
// TESTING
//   1. Load at 0x100, mem=0x1122334455667788, 2-cycle m_ready delay -> one m_rvalid ->
//      s_rvalid one cycle later with s_rdata=0x1122334455667788.
//   2. AMOADD.D at 0x200, mem=5, rs2=7 -> read then write of 12; s_rdata=5; mem=12.
//   3. AMOMIN.W at 0x204 (lane 1), mem lane=0xFFFFFFFF (-1), rs2=3 -> lane stays
//      0xFFFFFFFF, wmask=0xF0. AMOMINU with the same data -> lane becomes 3.
//   4. LR.D 0x300 then SC.D 0x300 -> write issued, s_rdata=0. A second SC -> no bus write,
//      s_rdata=1.
//   5. LR.W 0x300, then SW 0x304, then SC.W 0x300 -> SC fails with s_rdata=1 and m_valid
//      never asserted for the SC.
//   6. Assert rst while in WR_REQ of an AMO -> m_valid=0, s_ready=1 next cycle, no s_rvalid.
//      A subsequent load completes normally.

Source files
------------

// File: rtl/amo_sequencer.sv
// amo_sequencer
// Bridges the core data port to a single-outstanding memory bus. Plain loads and
// stores pass straight through, AMOs become a read-modify-write pair, and LR/SC is
// backed by a one-entry reservation. Only one request is ever in flight, so the
// aq/rl ordering bits need no action. The .W lane logic assumes a 64-bit data bus.
module amo_sequencer #(
   parameter int XLEN       = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [XLEN-1:0]         s_addr,
   input  logic                    s_wen,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wmask,
   input  logic                    s_is_amo,
   input  logic                    s_aq,
   input  logic                    s_rl,
   input  logic [4:0]              s_amoop,
   input  logic [2:0]              s_funct3,
   output logic                    s_rvalid,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [XLEN-1:0]         m_addr,
   output logic                    m_wen,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wmask,
   input  logic                    m_rvalid,
   input  logic [DATA_WIDTH-1:0]   m_rdata
);

   localparam int MW = DATA_WIDTH / 8;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SWAP = 5'b00001;
   localparam logic [4:0] OP_LR   = 5'b00010;
   localparam logic [4:0] OP_SC   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01100;
   localparam logic [4:0] OP_MIN  = 5'b10000;
   localparam logic [4:0] OP_MAX  = 5'b10100;
   localparam logic [4:0] OP_MINU = 5'b11000;
   localparam logic [4:0] OP_MAXU = 5'b11100;

   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      RESP
   } stateT;

   stateT r_state;
   stateT w_nextState;

   // Registered copy of the accepted request
   logic [XLEN-1:0]       r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [MW-1:0]         r_wmask;
   logic                  r_isAmo;
   logic [4:0]            r_amoop;
   logic [2:0]            r_funct3;

   // Response data: read data / old AMO value, or the SC status code
   logic [DATA_WIDTH-1:0] r_rdata;

   // Reservation set by LR
   logic                  r_rsvValid;
   logic [XLEN-1:0]       r_rsvAddr;

   logic                  w_accept;
   logic                  w_reqIsSc;
   logic                  w_scHit;
   logic                  w_rmw;
   logic                  w_isWord;
   logic                  w_writeHitsRsv;

   logic [31:0]           w_oldLane;
   logic [31:0]           w_srcLane;
   logic [31:0]           w_laneRes;
   logic [63:0]           w_dwRes;
   logic [DATA_WIDTH-1:0] w_amoResult;
   logic [DATA_WIDTH-1:0] w_writeData;

   logic                  w_unusedOrdering;

   // The ordering bits are deliberately dropped: a single request in flight is already strict order
   assign w_unusedOrdering = s_aq | s_rl;

   assign w_accept       = (r_state == IDLE) && s_valid;
   assign w_reqIsSc      = s_is_amo && (s_amoop == OP_SC);
   assign w_scHit        = r_rsvValid && (r_rsvAddr == s_addr);
   assign w_rmw          = r_isAmo && (r_amoop != OP_LR) && (r_amoop != OP_SC);
   assign w_isWord       = (r_funct3 == F3_WORD);
   assign w_writeHitsRsv = (r_addr[XLEN-1:3] == r_rsvAddr[XLEN-1:3]);

   // State register; reset abandons any sequence in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state selection: the request type picks the path out of IDLE
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (s_valid) begin
               if (w_reqIsSc) begin
                  w_nextState = w_scHit ? WR_REQ : RESP;
               end else if (s_is_amo) begin
                  w_nextState = RD_REQ;
               end else begin
                  w_nextState = s_wen ? WR_REQ : RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (m_ready) begin
               w_nextState = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (m_rvalid) begin
               w_nextState = w_rmw ? WR_REQ : RESP;
            end
         end
         WR_REQ: begin
            if (m_ready) begin
               w_nextState = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (m_rvalid) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Outputs depend only on registered state so the bus sees stable values until m_ready
   always_comb begin
      s_ready  = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      m_valid  = 1'b0;
      m_wen    = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wmask  = '0;
      case (r_state)
         IDLE: begin
            s_ready = 1'b1;
         end
         RD_REQ: begin
            m_valid = 1'b1;
            m_addr  = r_addr;
            m_wmask = r_wmask;
         end
         WR_REQ: begin
            m_valid = 1'b1;
            m_wen   = 1'b1;
            m_addr  = r_addr;
            m_wdata = w_writeData;
            m_wmask = r_wmask;
         end
         RESP: begin
            s_rvalid = 1'b1;
            s_rdata  = r_rdata;
         end
         default: begin
            s_ready = 1'b0;
         end
      endcase
   end

   // Capture the request on accept, and the read data when the bus returns it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_isAmo  <= 1'b0;
         r_amoop  <= '0;
         r_funct3 <= '0;
         r_rdata  <= '0;
      end else if (w_accept) begin
         r_addr   <= s_addr;
         r_wdata  <= s_wdata;
         r_wmask  <= s_wmask;
         r_isAmo  <= s_is_amo;
         r_amoop  <= s_amoop;
         r_funct3 <= s_funct3;
         // A failing SC answers 1 without touching the bus; everything else starts at 0
         r_rdata  <= (w_reqIsSc && !w_scHit) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if ((r_state == RD_WAIT) && m_rvalid) begin
         r_rdata  <= m_rdata;
      end
   end

   // Reservation: SC always consumes it, LR sets it, a write to the same doubleword kills it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsvValid <= 1'b0;
         r_rsvAddr  <= '0;
      end else if (w_accept && w_reqIsSc) begin
         r_rsvValid <= 1'b0;
      end else if ((r_state == RD_WAIT) && m_rvalid && r_isAmo && (r_amoop == OP_LR)) begin
         r_rsvValid <= 1'b1;
         r_rsvAddr  <= r_addr;
      end else if ((r_state == WR_REQ) && m_ready && w_writeHitsRsv) begin
         r_rsvValid <= 1'b0;
      end
   end

   // 32-bit AMO function on the lane picked by addr[2]
   always_comb begin
      w_oldLane = r_addr[2] ? r_rdata[63:32] : r_rdata[31:0];
      w_srcLane = r_addr[2] ? r_wdata[63:32] : r_wdata[31:0];
      case (r_amoop)
         OP_ADD:  w_laneRes = w_oldLane + w_srcLane;
         OP_SWAP: w_laneRes = w_srcLane;
         OP_XOR:  w_laneRes = w_oldLane ^ w_srcLane;
         OP_OR:   w_laneRes = w_oldLane | w_srcLane;
         OP_AND:  w_laneRes = w_oldLane & w_srcLane;
         OP_MIN:  w_laneRes = ($signed(w_oldLane) < $signed(w_srcLane)) ? w_oldLane : w_srcLane;
         OP_MAX:  w_laneRes = ($signed(w_oldLane) < $signed(w_srcLane)) ? w_srcLane : w_oldLane;
         OP_MINU: w_laneRes = (w_oldLane < w_srcLane) ? w_oldLane : w_srcLane;
         OP_MAXU: w_laneRes = (w_oldLane < w_srcLane) ? w_srcLane : w_oldLane;
         default: w_laneRes = w_oldLane;
      endcase
   end

   // 64-bit AMO function on the whole doubleword
   always_comb begin
      case (r_amoop)
         OP_ADD:  w_dwRes = r_rdata + r_wdata;
         OP_SWAP: w_dwRes = r_wdata;
         OP_XOR:  w_dwRes = r_rdata ^ r_wdata;
         OP_OR:   w_dwRes = r_rdata | r_wdata;
         OP_AND:  w_dwRes = r_rdata & r_wdata;
         OP_MIN:  w_dwRes = ($signed(r_rdata) < $signed(r_wdata)) ? r_rdata : r_wdata;
         OP_MAX:  w_dwRes = ($signed(r_rdata) < $signed(r_wdata)) ? r_wdata : r_rdata;
         OP_MINU: w_dwRes = (r_rdata < r_wdata) ? r_rdata : r_wdata;
         OP_MAXU: w_dwRes = (r_rdata < r_wdata) ? r_wdata : r_rdata;
         default: w_dwRes = r_rdata;
      endcase
   end

   // Write-data selection: for .W the untouched lane is written back as read
   always_comb begin
      if (w_isWord) begin
         w_amoResult = r_addr[2] ? {w_laneRes, r_rdata[31:0]} : {r_rdata[63:32], w_laneRes};
      end else begin
         w_amoResult = w_dwRes;
      end
      w_writeData = w_rmw ? w_amoResult : r_wdata;
   end

endmodule
